// File: rtl/data_mem_pipe.sv
// Single-port word memory with a pipelined read path, power-up zero-fill and
// out-of-range detection. One request per cycle once the zero-fill has finished.
module data_mem_pipe #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int DEPTH      = 262145,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              addr_err,
  output logic              init_busy
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_IDLE
  } state_e;

  localparam state_e RST_STATE = (CLR_ON_RST != 0) ? S_INIT : S_IDLE;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_init_addr;
  logic                r_req_ready;
  logic                w_accept;
  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_rd_word;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [RD_LAT-1:0]   r_vld;
  logic [DATA_W-1:0]   r_dat [RD_LAT];
  logic                r_addr_err;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first so that no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    init_busy    = 1'b0;
    case (r_state)
      S_INIT: begin
        init_busy = 1'b1;
        if (r_init_addr == LAST_ADDR) begin
          w_state_next = S_IDLE;
        end
      end
      S_IDLE:  w_state_next = S_IDLE;
      default: w_state_next = RST_STATE;
    endcase
  end

  // Zero-fill pointer and a registered ready that stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_addr <= '0;
      r_req_ready <= 1'b0;
    end else begin
      r_init_addr <= (r_state == S_INIT) ? r_init_addr + 1'b1 : '0;
      r_req_ready <= (w_state_next == S_IDLE);
    end
  end

  assign req_ready  = r_req_ready;
  assign w_accept   = req_valid & r_req_ready;
  // Compare one bit wider so DEPTH == 2**ADDR_W is representable.
  assign w_in_range = ({1'b0, req_addr} < DEPTH_X);
  assign w_idx      = req_addr[IDX_W-1:0];
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

  // NOTE: the storage array has no reset; clearing it is the job of the
  // zero-fill state, which keeps the array mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_init_addr[IDX_W-1:0]] <= '0;
    end else if (w_accept && req_write && w_in_range) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  // Read pipeline: data stages only load behind a valid, so rd_data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= '0;
      r_addr_err <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0]   <= w_accept & ~req_write;
      r_addr_err <= w_accept & ~w_in_range;
      if (w_accept && !req_write) begin
        r_dat[0] <= w_rd_word;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  assign rd_valid = r_vld[RD_LAT-1];
  assign rd_data  = r_dat[RD_LAT-1];
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: one instance with zero-fill and RD_LAT=2,
// one without zero-fill and RD_LAT=4.
module tb_data_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a = 1'b1, valid_a = 1'b0, write_a = 1'b0;
  logic [4:0] addr_a  = '0;
  logic [7:0] wdata_a = '0;
  logic       ready_a, rvld_a, err_a, busy_a;
  logic [7:0] rdata_a;

  logic       rst_n_b = 1'b1, valid_b = 1'b0, write_b = 1'b0;
  logic [4:0] addr_b  = '0;
  logic [7:0] wdata_b = '0;
  logic       ready_b, rvld_b, err_b, busy_b;
  logic [7:0] rdata_b;

  data_mem_pipe #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .RD_LAT(2), .CLR_ON_RST(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(write_a), .req_addr(addr_a), .req_wdata(wdata_a),
    .rd_valid(rvld_a), .rd_data(rdata_a), .addr_err(err_a), .init_busy(busy_a)
  );

  data_mem_pipe #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .RD_LAT(4), .CLR_ON_RST(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(write_b), .req_addr(addr_b), .req_wdata(wdata_b),
    .rd_valid(rvld_b), .rd_data(rdata_b), .addr_err(err_b), .init_busy(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int bad_ready;

  logic [31:0] rsp_cyc_a[$], rsp_dat_a[$], err_cyc_a[$];
  logic [31:0] rsp_cyc_b[$], rsp_dat_b[$];
  int          err_cnt_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response log, sampled mid-cycle and tagged with the current cycle number.
  always @(negedge clk) begin
    if (rvld_a === 1'b1) begin
      rsp_cyc_a.push_back(32'(cyc));
      rsp_dat_a.push_back(32'(rdata_a));
    end
    if (err_a === 1'b1) err_cyc_a.push_back(32'(cyc));
    if (rvld_b === 1'b1) begin
      rsp_cyc_b.push_back(32'(cyc));
      rsp_dat_b.push_back(32'(rdata_b));
    end
    if (err_b === 1'b1) err_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_a();
    rsp_cyc_a.delete();
    rsp_dat_a.delete();
    err_cyc_a.delete();
  endtask

  // Present one request on dut_a for one edge; c is the presenting cycle.
  task automatic req_a(input logic wr, input logic [4:0] ad, input logic [7:0] wd, output int c);
    valid_a = 1'b1;
    write_a = wr;
    addr_a  = ad;
    wdata_a = wd;
    c       = cyc;
    tick();
    valid_a = 1'b0;
  endtask

  task automatic count_busy_a(output int n);
    n = 0;
    while (busy_a && n < 40) begin
      if (ready_a) bad_ready++;
      n++;
      tick();
    end
  endtask

  initial begin
    int n, cw, cr, c0, cb;
    int c_arr[16];

    // Reset asserted asynchronously, before any clock edge.
    #1;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    #2;
    check("rst_ready_a", 32'(ready_a), 0);
    check("rst_busy_a",  32'(busy_a),  1);
    check("rst_rvld_a",  32'(rvld_a),  0);
    check("rst_rdata_a", 32'(rdata_a), 0);
    check("rst_err_a",   32'(err_a),   0);
    check("rst_ready_b", 32'(ready_b), 0);
    check("rst_busy_b",  32'(busy_b),  0);

    idle(3);
    rst_n_a   = 1'b1;
    rst_n_b   = 1'b1;
    bad_ready = 0;
    count_busy_a(n);
    check("init_cycles",       32'(n),         16);
    check("ready_in_init",     32'(bad_ready), 0);
    check("ready_after_init",  32'(ready_a),   1);

    // Zero-filled contents, back-to-back reads.
    clear_a();
    for (int a = 0; a < 16; a++) req_a(1'b0, 5'(a), 8'h00, c_arr[a]);
    idle(4);
    check("zf_count", 32'(rsp_dat_a.size()), 16);
    for (int a = 0; a < 16; a++) begin
      check($sformatf("zf_data%0d", a), q_at(rsp_dat_a, a), 0);
      check($sformatf("zf_cyc%0d", a),  q_at(rsp_cyc_a, a), 32'(c_arr[a] + 2));
    end

    // Read-after-write on the following cycle.
    clear_a();
    req_a(1'b1, 5'd3, 8'hA5, cw);
    req_a(1'b0, 5'd3, 8'h00, cr);
    idle(4);
    check("raw_count", 32'(rsp_dat_a.size()), 1);
    check("raw_cyc",   q_at(rsp_cyc_a, 0), 32'(cr + 2));
    check("raw_data",  q_at(rsp_dat_a, 0), 32'hA5);

    // Streaming reads.
    clear_a();
    req_a(1'b1, 5'd1, 8'h11, cw);
    req_a(1'b1, 5'd2, 8'h22, cw);
    req_a(1'b1, 5'd3, 8'h33, cw);
    req_a(1'b0, 5'd1, 8'h00, c0);
    req_a(1'b0, 5'd2, 8'h00, cr);
    req_a(1'b0, 5'd3, 8'h00, cr);
    idle(5);
    check("str_count", 32'(rsp_dat_a.size()), 3);
    check("str_cyc0",  q_at(rsp_cyc_a, 0), 32'(c0 + 2));
    check("str_cyc1",  q_at(rsp_cyc_a, 1), 32'(c0 + 3));
    check("str_cyc2",  q_at(rsp_cyc_a, 2), 32'(c0 + 4));
    check("str_data0", q_at(rsp_dat_a, 0), 32'h11);
    check("str_data1", q_at(rsp_dat_a, 1), 32'h22);
    check("str_data2", q_at(rsp_dat_a, 2), 32'h33);
    check("str_no_err", 32'(err_cyc_a.size()), 0);
    check("hold_rvld", 32'(rvld_a),  0);
    check("hold_data", 32'(rdata_a), 32'h33);

    // Out-of-range write and read at addr 16 (would alias addr 0 if wrapped).
    clear_a();
    req_a(1'b1, 5'd16, 8'hFF, cw);
    req_a(1'b0, 5'd16, 8'h00, cr);
    idle(4);
    check("oor_err_count", 32'(err_cyc_a.size()), 2);
    check("oor_err_w",     q_at(err_cyc_a, 0), 32'(cw + 1));
    check("oor_err_r",     q_at(err_cyc_a, 1), 32'(cr + 1));
    check("oor_rd_count",  32'(rsp_dat_a.size()), 1);
    check("oor_rd_cyc",    q_at(rsp_cyc_a, 0), 32'(cr + 2));
    check("oor_rd_data",   q_at(rsp_dat_a, 0), 0);
    clear_a();
    req_a(1'b0, 5'd0, 8'h00, cr);
    idle(4);
    check("addr0_kept", q_at(rsp_dat_a, 0), 0);

    // Reset with a read in flight, then reset again partway through zero-fill.
    req_a(1'b1, 5'd5, 8'h77, cw);
    clear_a();
    req_a(1'b0, 5'd5, 8'h00, cr);
    rst_n_a = 1'b0;
    #1;
    check("midrst_ready", 32'(ready_a), 0);
    check("midrst_busy",  32'(busy_a),  1);
    check("midrst_rvld",  32'(rvld_a),  0);
    idle(3);
    rst_n_a = 1'b1;
    check("rel_busy", 32'(busy_a), 1);
    idle(5);
    check("flushed_rd", 32'(rsp_dat_a.size()), 0);
    rst_n_a = 1'b0;
    idle(2);
    rst_n_a   = 1'b1;
    bad_ready = 0;
    count_busy_a(n);
    check("restart_cycles", 32'(n),         16);
    check("restart_ready",  32'(bad_ready), 0);
    clear_a();
    req_a(1'b0, 5'd5, 8'h00, cr);
    req_a(1'b0, 5'd1, 8'h00, cr);
    idle(4);
    check("restart_data5", q_at(rsp_dat_a, 0), 0);
    check("restart_data1", q_at(rsp_dat_a, 1), 0);

    // Retention across reset without zero-fill, RD_LAT=4.
    check("b_ready", 32'(ready_b), 1);
    check("b_busy",  32'(busy_b),  0);
    valid_b = 1'b1; write_b = 1'b1; addr_b = 5'd7; wdata_b = 8'h5A;
    tick();
    valid_b = 1'b0;
    rst_n_b = 1'b0;
    #1;
    check("b_rst_ready", 32'(ready_b), 0);
    check("b_rst_busy",  32'(busy_b),  0);
    idle(2);
    rst_n_b = 1'b1;
    tick();
    check("b_ready_first_edge", 32'(ready_b), 1);
    rsp_cyc_b.delete();
    rsp_dat_b.delete();
    valid_b = 1'b1; write_b = 1'b0; addr_b = 5'd7;
    cb = cyc;
    tick();
    valid_b = 1'b0;
    idle(6);
    check("b_rd_count", 32'(rsp_dat_b.size()), 1);
    check("b_rd_cyc",   q_at(rsp_cyc_b, 0), 32'(cb + 4));
    check("b_rd_data",  q_at(rsp_dat_b, 0), 32'h5A);
    check("b_no_err",   32'(err_cnt_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 19, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 262145, number of words; legal range 2..2^ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-005 SHALL have parameter CLR_ON_RST, default 1; 1 zero-fills memory after reset.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-010 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, ADDR_W, word address.
REQ-012 SHALL have port req_wdata, input, DATA_W, write data.
REQ-013 SHALL have port rd_valid, output, 1, one-cycle pulse marking valid rd_data.
REQ-014 SHALL have port rd_data, output, DATA_W, read data.
REQ-015 SHALL have port addr_err, output, 1, one-cycle pulse flagging an out-of-range request.
REQ-016 SHALL have port init_busy, output, 1, zero-fill in progress.

Function
REQ-017 SHALL implement FSM states INIT and IDLE; reset enters INIT if CLR_ON_RST=1, else IDLE.
REQ-018 In INIT, SHALL write 0 to addresses 0..DEPTH-1, one per cycle in ascending order, then enter IDLE; INIT lasts exactly DEPTH cycles.
REQ-019 SHALL drive req_ready=0 and init_busy=1 in INIT; req_ready=1 and init_busy=0 in IDLE.
REQ-020 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1; no other request is accepted, and inputs are ignored otherwise.
REQ-021 An accepted in-range write SHALL update mem[req_addr] at the accepting edge and produce no rd_valid.
REQ-022 An accepted in-range read SHALL produce rd_valid=1 with rd_data=mem[req_addr] exactly RD_LAT cycles after the accepting edge.
REQ-023 SHALL sustain one request per cycle in IDLE with no bubbles; responses emerge in request order.
REQ-024 A read accepted the cycle after a write to the same address SHALL return the new data (read-after-write).
REQ-025 A request with req_addr >= DEPTH SHALL be out of range; writes leave memory unchanged.
REQ-026 An out-of-range read SHALL still produce rd_valid at RD_LAT with rd_data=0.
REQ-027 For any out-of-range request, addr_err SHALL be 1 for exactly the cycle following the accepting edge.
REQ-028 rd_data SHALL hold its last value while rd_valid=0.
REQ-029 Address arithmetic SHALL be unsigned ADDR_W; no wrap-around of out-of-range addresses onto legal words.

Reset
REQ-030 On rst_n=0, SHALL asynchronously force rd_valid=0, rd_data=0, addr_err=0, req_ready=0, init_busy=CLR_ON_RST.
REQ-031 Reset SHALL flush all in-flight reads; no rd_valid is produced for requests accepted before reset.
REQ-032 Reset asserted during INIT SHALL restart zero-fill from address 0 after release.
REQ-033 With CLR_ON_RST=0, memory contents SHALL be retained across reset; req_ready=1 from the first edge after release.

Verification (DEPTH=16, ADDR_W=5, DATA_W=8, RD_LAT=2 unless noted)
REQ-034 Release reset, CLR_ON_RST=1 -> init_busy=1 and req_ready=0 for 16 cycles, then req_ready=1; reads of addresses 0..15 all return 0x00.
REQ-035 Write 0xA5 to addr 3, read addr 3 on the next cycle -> rd_valid exactly 2 cycles after the read acceptance, with rd_data=0xA5.
REQ-036 Back-to-back reads of addr 1,2,3 holding 0x11,0x22,0x33 -> rd_valid on three consecutive cycles, data 0x11,0x22,0x33 in order.
REQ-037 Write 0xFF to addr 16, then read addr 16 -> addr_err pulses once per request; the read returns rd_data=0x00 with rd_valid; addr 0 is unchanged.
REQ-038 Issue a read, assert rst_n=0 one cycle later -> no rd_valid appears; after release init_busy=1 and zero-fill restarts at addr 0.
REQ-039 CLR_ON_RST=0, RD_LAT=4: write 0x5A to addr 7, reset, then read addr 7 -> rd_data=0x5A, 4 cycles after acceptance.
